// File: rtl/layer_neuron_sequencer.sv
// Avalon-MM slave that runs each neuron of one FFNN layer on the shared datapath and buffers the outputs for CPU readback.
// Optional build macro LAYER_SEQ_TIMEOUT_EN adds a WAIT-state watchdog (TIMEOUT_CYCLES) reported as STATUS bit3.
module layer_neuron_sequencer #(
   parameter int DATA_W      = 9,
   parameter int MAX_NEURONS = 8,
   parameter int IDX_W       = 3
`ifdef LAYER_SEQ_TIMEOUT_EN
   ,parameter int TIMEOUT_CYCLES = 1024
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        address,
   input  logic              write,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic              neuron_start,
   output logic [IDX_W-1:0]  neuron_sel,
   input  logic              neuron_done,
   input  logic [DATA_W-1:0] neuron_data,
   output logic              irq
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;
   localparam logic [IDX_W:0] LP_MAX = (IDX_W+1)'(MAX_NEURONS);

   logic [1:0]        r_state;
   logic [IDX_W-1:0]  r_idx;
   logic [IDX_W-1:0]  r_sel;
   logic [IDX_W:0]    r_num;
   logic              r_done;
   logic              r_irq_en;
   logic [DATA_W-1:0] r_result [MAX_NEURONS];

   logic              w_ctrl_wr;
   logic              w_start_acc;
   logic              w_abort;
   logic              w_clr;
   logic              w_busy;
   logic              w_last;
   logic              w_timeout;
   logic              w_err;
   logic [IDX_W:0]    w_num_in;
   logic [IDX_W:0]    w_num_clamp;
   logic              w_unused;

   assign w_ctrl_wr   = write && (address == 2'd0);
   assign w_abort     = w_ctrl_wr && writedata[1];
   assign w_clr       = w_ctrl_wr && writedata[2];
   // Abort outranks start; start is only taken from IDLE, so busy starts drop out here.
   assign w_start_acc = w_ctrl_wr && writedata[0] && !writedata[1] && (r_state == ST_IDLE);
   assign w_busy      = (r_state == ST_START) || (r_state == ST_WAIT);
   assign w_last      = ({1'b0, r_idx} == (r_num - 1'b1));
   assign w_num_in    = writedata[IDX_W:0];
   assign w_num_clamp = (w_num_in > LP_MAX) ? LP_MAX : w_num_in;
   assign w_unused    = ^writedata;

   assign neuron_start = (r_state == ST_START);
   assign neuron_sel   = r_idx;
   assign irq          = r_done && r_irq_en;

`ifdef LAYER_SEQ_TIMEOUT_EN
   localparam int LP_TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [LP_TO_W-1:0] r_to_cnt;
   logic               r_err;

   assign w_timeout = (r_state == ST_WAIT) && !neuron_done &&
                      (r_to_cnt == LP_TO_W'(TIMEOUT_CYCLES - 1));
   assign w_err     = r_err;

   // Counter is zeroed in START so it starts from 0 on every WAIT entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_to_cnt <= '0;
         r_err    <= 1'b0;
      end else begin
         if (r_state == ST_START)
            r_to_cnt <= '0;
         else if (r_state == ST_WAIT)
            r_to_cnt <= r_to_cnt + 1'b1;
         if (w_start_acc || w_clr)
            r_err <= 1'b0;
         if (w_timeout && !w_abort)
            r_err <= 1'b1;
      end
   end
`else
   assign w_timeout = 1'b0;
   assign w_err     = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_idx    <= '0;
         r_sel    <= '0;
         r_num    <= '0;
         r_done   <= 1'b0;
         r_irq_en <= 1'b0;
         for (int i = 0; i < MAX_NEURONS; i++)
            r_result[i] <= '0;
      end else begin
         if (w_ctrl_wr)
            r_irq_en <= writedata[3];
         if (write && (address == 2'd1) && !w_busy)
            r_num <= w_num_clamp;
         if (write && (address == 2'd2))
            r_sel <= writedata[IDX_W-1:0];
         if (w_clr)
            r_done <= 1'b0;

         if (w_abort) begin
            r_state <= ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_start_acc) begin
                     r_done  <= 1'b0;
                     r_idx   <= '0;
                     r_state <= (r_num == '0) ? ST_DONE : ST_START;
                  end
               end
               ST_START: r_state <= ST_WAIT;
               ST_WAIT: begin
                  if (neuron_done) begin
                     r_result[r_idx] <= neuron_data;
                     if (w_last) begin
                        r_state <= ST_DONE;
                     end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= ST_START;
                     end
                  end else if (w_timeout) begin
                     r_done  <= 1'b1;
                     r_state <= ST_IDLE;
                  end
               end
               default: begin
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         readdata <= '0;
      end else begin
         case (address)
            2'd0:    readdata <= {{(24-IDX_W){1'b0}}, r_idx, 4'b0000, w_err, r_irq_en, r_done, w_busy};
            2'd1:    readdata <= {{(31-IDX_W){1'b0}}, r_num};
            2'd3:    readdata <= {{(32-DATA_W){1'b0}}, r_result[r_sel]};
            default: readdata <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_layer_neuron_sequencer.sv
// Bench for layer_neuron_sequencer: register-map vector table, directed layer runs, and randomized layers vs a simple model.
module tb_layer_neuron_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        neuron_start;
   logic [2:0]  neuron_sel;
   logic        neuron_done;
   logic [8:0]  neuron_data;
   logic        irq;

   logic        dp_done;
   logic [8:0]  dp_data;
   logic        spur_done;
   logic        dp_en;
   int          dp_lat;
   logic [8:0]  dp_q[$];
   int          sel_log[$];
   logic [8:0]  exp_res [8];
   int          total = 0;
   int          bad   = 0;

   assign neuron_done = dp_done | spur_done;
   assign neuron_data = spur_done ? 9'h1FF : dp_data;

   always #5 clk = ~clk;

   layer_neuron_sequencer #(
      .DATA_W(9), .MAX_NEURONS(8), .IDX_W(3)
`ifdef LAYER_SEQ_TIMEOUT_EN
      , .TIMEOUT_CYCLES(16)
`endif
   ) dut (
      .clk(clk), .reset(reset), .address(address), .write(write),
      .writedata(writedata), .readdata(readdata), .neuron_start(neuron_start),
      .neuron_sel(neuron_sel), .neuron_done(neuron_done), .neuron_data(neuron_data),
      .irq(irq)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; write = 1'b1;
      tick();
      write = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      address = a;
      tick();
      d = readdata;
   endtask

   task automatic rd_result(input int k, output logic [31:0] d);
      wr(2'd2, 32'(k));
      rd(2'd3, d);
   endtask

   task automatic wait_done(input string name);
      logic [31:0] d;
      bit ok = 0;
      for (int i = 0; i < 400 && !ok; i++) begin
         rd(2'd0, d);
         if (d[1]) ok = 1;
      end
      check({name, "_done_seen"}, 32'(ok), 32'd1);
   endtask

   task automatic wait_start_sel(input int s, input string name);
      bit ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (neuron_start && neuron_sel == 3'(s)) ok = 1;
         else tick();
      end
      check({name, "_start_seen"}, 32'(ok), 32'd1);
   endtask

   task automatic check_results(input string name);
      logic [31:0] d;
      for (int k = 0; k < 8; k++) begin
         rd_result(k, d);
         check($sformatf("%s_res%0d", name, k), d, {23'd0, exp_res[k]});
      end
   endtask

   task automatic check_sels(input int base, input int n, input string name);
      check({name, "_start_count"}, 32'(sel_log.size() - base), 32'(n));
      for (int k = 0; k < n && base + k < sel_log.size(); k++)
         check($sformatf("%s_sel%0d", name, k), 32'(sel_log[base+k]), 32'(k));
   endtask

   // Datapath stand-in: answers each start after dp_lat cycles with the next queued value.
   initial begin
      dp_done = 1'b0;
      dp_data = '0;
      forever begin
         if (neuron_start && dp_en) begin
            dp_data = (dp_q.size() > 0) ? dp_q.pop_front() : 9'($urandom);
            repeat (dp_lat) tick();
            dp_done = 1'b1;
            tick();
            dp_done = 1'b0;
         end else begin
            tick();
         end
      end
   end

   always @(negedge clk)
      if (neuron_start) sel_log.push_back(int'(neuron_sel));

   typedef struct {
      bit          is_wr;
      logic [1:0]  addr;
      logic [31:0] data;
   } vec_t;

   initial begin
      vec_t        vt [18];
      logic [31:0] d;
      int          base;
      int          n;
      int          v;
      logic [8:0]  val;

      vt[0]  = '{0, 2'd0, 32'h0};   vt[1]  = '{0, 2'd1, 32'h0};
      vt[2]  = '{0, 2'd2, 32'h0};   vt[3]  = '{0, 2'd3, 32'h0};
      vt[4]  = '{1, 2'd1, 32'd15};  vt[5]  = '{0, 2'd1, 32'd8};
      vt[6]  = '{1, 2'd1, 32'd5};   vt[7]  = '{0, 2'd1, 32'd5};
      vt[8]  = '{1, 2'd1, 32'd9};   vt[9]  = '{0, 2'd1, 32'd8};
      vt[10] = '{1, 2'd0, 32'h8};   vt[11] = '{0, 2'd0, 32'h4};
      vt[12] = '{1, 2'd0, 32'h4};   vt[13] = '{0, 2'd0, 32'h0};
      vt[14] = '{1, 2'd2, 32'd5};   vt[15] = '{0, 2'd3, 32'h0};
      vt[16] = '{1, 2'd1, 32'd0};   vt[17] = '{0, 2'd1, 32'd0};

      reset = 1'b1; address = '0; write = 1'b0; writedata = '0;
      spur_done = 1'b0; dp_en = 1'b1; dp_lat = 4;
      for (int k = 0; k < 8; k++) exp_res[k] = '0;
      repeat (3) tick();
      reset = 1'b0;
      check("rst_readdata", readdata, 32'h0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_start", 32'(neuron_start), 32'd0);
      check("rst_sel", 32'(neuron_sel), 32'd0);

      for (int i = 0; i < 18; i++) begin
         if (vt[i].is_wr) wr(vt[i].addr, vt[i].data);
         else begin
            rd(vt[i].addr, d);
            check($sformatf("vec%0d_addr%0d", i, vt[i].addr), d, vt[i].data);
         end
      end

      // Three-neuron layer, 4-cycle datapath latency
      wr(2'd1, 32'd3);
      dp_q = '{9'h1A5, 9'h003, 9'h100};
      dp_lat = 4;
      base = sel_log.size();
      wr(2'd0, 32'h9);
      wait_done("layer3");
      check_sels(base, 3, "layer3");
      check("layer3_irq", 32'(irq), 32'd1);
      rd(2'd0, d);
      check("layer3_status", d & 32'hF, 32'h6);
      exp_res[0] = 9'h1A5; exp_res[1] = 9'h003; exp_res[2] = 9'h100;
      check_results("layer3");

      // Empty layer: done two cycles after the start write, never pulses the datapath
      wr(2'd1, 32'd0);
      base = sel_log.size();
      wr(2'd0, 32'h9);
      check("empty_irq_c1", 32'(irq), 32'd0);
      tick();
      check("empty_irq_c2", 32'(irq), 32'd1);
      repeat (4) tick();
      check("empty_no_start", 32'(sel_log.size() - base), 32'd0);

      // Start and NUM_NEURONS writes while busy, then a stray done in IDLE
      wr(2'd1, 32'd3);
      dp_q = '{9'h0A1, 9'h0B2, 9'h0C3};
      dp_lat = 6;
      base = sel_log.size();
      wr(2'd0, 32'h9);
      wait_start_sel(1, "busy");
      tick();
      wr(2'd0, 32'h9);
      wr(2'd1, 32'd7);
      wait_done("busy");
      check_sels(base, 3, "busy");
      rd(2'd1, d);
      check("busy_num_kept", d, 32'd3);
      exp_res[0] = 9'h0A1; exp_res[1] = 9'h0B2; exp_res[2] = 9'h0C3;
      base = sel_log.size();
      spur_done = 1'b1; tick(); spur_done = 1'b0;
      repeat (3) tick();
      check("spur_no_start", 32'(sel_log.size() - base), 32'd0);
      rd(2'd0, d);
      check("spur_status", d & 32'h3, 32'h2);
      check_results("spur");

      // Abort during WAIT of neuron 2
      dp_q = '{9'h011, 9'h022, 9'h033};
      dp_lat = 8;
      wr(2'd0, 32'h9);
      wait_start_sel(2, "abort");
      tick();
      wr(2'd0, 32'h2);
      check("abort_start_low", 32'(neuron_start), 32'd0);
      rd(2'd0, d);
      check("abort_status", d & 32'h3, 32'h0);
      repeat (12) tick();
      exp_res[0] = 9'h011; exp_res[1] = 9'h022;
      check_results("abort");

      // Reset in the middle of a layer
      dp_q = '{9'h155, 9'h0AA, 9'h077};
      wr(2'd0, 32'h1);
      wait_start_sel(1, "mreset");
      tick();
      reset = 1'b1; tick(); reset = 1'b0;
      check("mreset_sel", 32'(neuron_sel), 32'd0);
      check("mreset_irq", 32'(irq), 32'd0);
      repeat (12) tick();
      dp_q.delete();
      for (int k = 0; k < 8; k++) exp_res[k] = '0;
      check_results("mreset");
      rd(2'd1, d);
      check("mreset_num", d, 32'd0);

`ifdef LAYER_SEQ_TIMEOUT_EN
      // Watchdog: datapath never answers
      dp_en = 1'b0;
      wr(2'd1, 32'd1);
      wr(2'd0, 32'h9);
      repeat (16) tick();
      check("to_irq_before", 32'(irq), 32'd0);
      tick();
      check("to_irq_after", 32'(irq), 32'd1);
      rd(2'd0, d);
      check("to_status", d & 32'hF, 32'hE);
      wr(2'd0, 32'hC);
      rd(2'd0, d);
      check("to_cleared", d & 32'hF, 32'h4);
      dp_en = 1'b1;
`endif

      // Randomized layers against the model
      for (int it = 0; it < 10; it++) begin
         v = int'($urandom_range(0, 15));
         n = (v > 8) ? 8 : v;
         wr(2'd1, 32'(v));
         rd(2'd1, d);
         check($sformatf("rnd%0d_num", it), d, 32'(n));
         dp_lat = int'($urandom_range(1, 5));
         for (int k = 0; k < n; k++) begin
            val = 9'($urandom);
            dp_q.push_back(val);
            exp_res[k] = val;
         end
         base = sel_log.size();
         wr(2'd0, 32'h1);
         wait_done($sformatf("rnd%0d", it));
         check_sels(base, n, $sformatf("rnd%0d", it));
         check_results($sformatf("rnd%0d", it));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
